l2_responder_fsm: RTL and testbench

L2-side responder for the L1 nonblocking cache miss protocol. Accepts line read-miss and write-back requests from the L1 controller and buffers them in an in-order request queue. Services each request against an internal line store with a fixed access latency, and returns read fills with a one-cycle `done_l2` pulse. Flow control uses the `stall_l2` nack the L1 FSM already obeys. Sits between the L1 miss FSM and backing memory; doubles as the L2 model in L1 benches.

---
 rtl/l2_responder_fsm.sv | 118 +++++++++++
 tb/tb_l2_responder_fsm.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/l2_responder_fsm.sv
// l2_responder_fsm: L2 responder for L1 miss traffic. Holds requests in an in-order queue and
// services them against a line store with fixed latency; read fills pulse done_l2.
module l2_responder_fsm #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 128,
   parameter int QDEPTH    = 4,
   parameter int LATENCY   = 4,
   parameter int MEM_LINES = 256
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              valid_l1,
   input  logic              rw_l1,
   input  logic [ADDR_W-1:0] addr_l1,
   input  logic [DATA_W-1:0] wdata_l1,
   output logic              stall_l2,
   output logic              done_l2,
   output logic [DATA_W-1:0] rdata_l2,
   output logic [ADDR_W-1:0] done_addr,
   output logic              busy
);
   localparam int OFF = $clog2(DATA_W / 8);
   localparam int IDX = $clog2(MEM_LINES);
   localparam int PW  = $clog2(QDEPTH);
   localparam int OW  = $clog2(QDEPTH + 1);
   localparam int CW  = $clog2(LATENCY + 1);

   typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

   state_t            state, state_nxt;
   logic              q_rw    [QDEPTH];
   logic [ADDR_W-1:0] q_addr  [QDEPTH];
   logic [DATA_W-1:0] q_wdata [QDEPTH];
   // Store is zero at power-up and deliberately untouched by reset.
   logic [DATA_W-1:0] mem     [MEM_LINES] = '{default: '0};
   logic [PW-1:0]     wptr, rptr;
   logic [OW-1:0]     occ, occ_nxt;
   logic [CW-1:0]     cnt;
   logic              s_rw;
   logic [ADDR_W-1:0] s_addr;
   logic [DATA_W-1:0] s_wdata;
   logic [IDX-1:0]    s_idx;
   logic              push, pop, dec, commit, fill;

   assign push    = valid_l1 & ~stall_l2;
   assign occ_nxt = occ + OW'(push) - OW'(pop);
   assign s_idx   = s_addr[OFF+IDX-1:OFF];

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      dec       = 1'b0;
      commit    = 1'b0;
      fill      = 1'b0;
      case (state)
         IDLE: begin
            pop       = occ != '0;
            state_nxt = pop ? ACCESS : IDLE;
         end
         ACCESS: begin
            dec       = cnt != '0;
            commit    = !dec && s_rw;
            fill      = !dec && !s_rw;
            state_nxt = dec ? ACCESS : (s_rw ? IDLE : RESPOND);
         end
         RESPOND: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clock) begin
      if (push) begin
         q_rw[wptr]    <= rw_l1;
         q_addr[wptr]  <= addr_l1;
         q_wdata[wptr] <= wdata_l1;
      end
      if (commit) mem[s_idx] <= s_wdata;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wptr      <= '0;
         rptr      <= '0;
         occ       <= '0;
         stall_l2  <= 1'b0;
         busy      <= 1'b0;
         done_l2   <= 1'b0;
         rdata_l2  <= '0;
         done_addr <= '0;
         s_rw      <= 1'b0;
         s_addr    <= '0;
         s_wdata   <= '0;
         cnt       <= '0;
      end else begin
         occ      <= occ_nxt;
         stall_l2 <= occ_nxt == OW'(QDEPTH);
         busy     <= (occ_nxt != '0) || (state_nxt != IDLE);
         done_l2  <= fill;
         if (push) wptr <= wptr + PW'(1);
         if (pop) begin
            rptr    <= rptr + PW'(1);
            s_rw    <= q_rw[rptr];
            s_addr  <= q_addr[rptr];
            s_wdata <= q_wdata[rptr];
            cnt     <= CW'(LATENCY - 1);
         end else if (dec) cnt <= cnt - CW'(1);
         if (fill) begin
            rdata_l2  <= mem[s_idx];
            done_addr <= s_addr;
         end
      end
   end
endmodule

// File: tb/tb_l2_responder_fsm.sv
// tb_l2_responder_fsm: scoreboard bench; expected fills are computed at acceptance time from an
// array model of the line store, and a negedge monitor compares every done_l2 pulse.
module tb_l2_responder_fsm;
   logic         clock, reset, valid_l1, rw_l1;
   logic [31:0]  addr_l1;
   logic [127:0] wdata_l1;
   logic         stall_l2, done_l2, busy;
   logic [127:0] rdata_l2;
   logic [31:0]  done_addr;

   l2_responder_fsm dut (
      .clock(clock), .reset(reset), .valid_l1(valid_l1), .rw_l1(rw_l1), .addr_l1(addr_l1),
      .wdata_l1(wdata_l1), .stall_l2(stall_l2), .done_l2(done_l2), .rdata_l2(rdata_l2),
      .done_addr(done_addr), .busy(busy)
   );

   typedef struct packed {
      logic [31:0]  a;
      logic [127:0] d;
   } exp_t;

   exp_t         expq[$];
   logic [127:0] mm[256];
   int           n_checks = 0, n_fail = 0, n_done = 0;
   bit           acc;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic int idx(input logic [31:0] a);
      return (a / 16) % 256;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   // Presents one request for one cycle; the model is updated only if the DUT accepts it.
   task automatic send(input logic rw, input logic [31:0] a, input logic [127:0] d, output bit ok);
      valid_l1 = 1'b1;
      rw_l1    = rw;
      addr_l1  = a;
      wdata_l1 = d;
      ok       = !stall_l2;
      if (ok) begin
         if (rw) mm[idx(a)] = d;
         else expq.push_back('{a: a, d: mm[idx(a)]});
      end
      tick();
      valid_l1 = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((busy || expq.size() != 0) && n < 300) begin
         tick();
         n++;
      end
      check(name, n < 300 && expq.size() == 0, 1'b1);
   endtask

   initial begin : monitor
      bit prev = 1'b0;
      exp_t e;
      forever begin
         @(negedge clock);
         if (!reset) prev = 1'b0;
         else begin
            if (done_l2) begin
               n_done++;
               check("done_consecutive", prev, 1'b0);
               if (expq.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL spurious_done: got pulse at addr %h expected none", done_addr);
               end else begin
                  e = expq.pop_front();
                  check("done_addr", done_addr, e.a);
                  check("rdata", rdata_l2, e.d);
               end
            end
            prev = done_l2;
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL timeout: got no end of test expected finish");
      $fatal(1);
   end

   initial begin
      int n0, n;
      logic [127:0] p, q;
      for (int i = 0; i < 256; i++) mm[i] = '0;
      reset = 1'b0; valid_l1 = 1'b0; rw_l1 = 1'b0; addr_l1 = '0; wdata_l1 = '0;
      repeat (3) tick();
      check("rst_stall", stall_l2, 0);
      check("rst_done", done_l2, 0);
      check("rst_rdata", rdata_l2, 0);
      check("rst_done_addr", done_addr, 0);
      check("rst_busy", busy, 0);
      reset = 1'b1;
      tick();

      // First read latency: pulse only in cycle 6, busy low from cycle 7.
      send(1'b0, 32'h40, '0, acc);
      check("lat_acc", acc, 1);
      for (int k = 1; k <= 7; k++) begin
         check("lat_done", done_l2, k == 6);
         check("lat_busy", busy, k <= 6);
         tick();
      end
      drain("lat_drain");

      // Write then read the same line.
      n0 = n_done;
      send(1'b1, 32'h40, {16{8'hA5}}, acc);
      send(1'b0, 32'h40, '0, acc);
      drain("wr_rd_drain");
      check("wr_rd_pulses", n_done - n0, 1);

      // Back-to-back reads: fifth fills the queue, sixth is stalled.
      n0 = n_done;
      for (int k = 0; k < 5; k++) begin
         send(1'b0, 32'h100 + k * 16, '0, acc);
         check("af_acc", acc, 1);
      end
      check("af_stall", stall_l2, 1);
      send(1'b0, 32'h150, '0, acc);
      check("af_drop", acc, 0);
      n = 0;
      while (!acc && n < 50) begin
         send(1'b0, 32'h150, '0, acc);
         n++;
      end
      check("af_reaccept", acc, 1);
      drain("af_drain");
      check("af_pulses", n_done - n0, 6);

      // Push coinciding with an IDLE pop at occupancy 3.
      for (int k = 0; k < 4; k++) send(1'b0, 32'h200 + k * 16, '0, acc);
      repeat (3) tick();
      send(1'b0, 32'h240, '0, acc);
      check("occ3_acc", acc, 1);
      check("occ3_stall", stall_l2, 0);
      send(1'b0, 32'h250, '0, acc);
      check("occ4_stall", stall_l2, 1);
      drain("occ_drain");

      // Index aliasing across upper address bits.
      send(1'b1, 32'h0010, {4{32'h1111_2222}}, acc);
      send(1'b1, 32'h1010, {4{32'h3333_4444}}, acc);
      send(1'b0, 32'h0010, '0, acc);
      drain("alias_drain");
      check("alias_model", mm[1], {4{32'h3333_4444}});

      // Reset during a write's ACCESS: the write is lost.
      p = {4{32'hCAFE_0001}};
      q = {4{32'hDEAD_0002}};
      send(1'b1, 32'h80, p, acc);
      drain("pre_drain");
      send(1'b1, 32'h80, q, acc);
      tick();
      tick();
      reset = 1'b0;
      #1;
      check("mid_rst_done", done_l2, 0);
      check("mid_rst_rdata", rdata_l2, 0);
      check("mid_rst_addr", done_addr, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_stall", stall_l2, 0);
      tick();
      tick();
      expq.delete();
      mm[idx(32'h80)] = p;
      reset = 1'b1;
      n0 = n_done;
      repeat (10) tick();
      check("post_rst_quiet", n_done - n0, 0);
      send(1'b0, 32'h80, '0, acc);
      drain("post_rst_drain");
      check("post_rst_pulses", n_done - n0, 1);

      // Random traffic over a few aliasing lines.
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 1) == 1)
            send(1'(($urandom_range(0, 2)) == 0),
                 ($urandom_range(0, 3) << 12) | ($urandom_range(0, 7) << 4) | $urandom_range(0, 15),
                 {$urandom, $urandom, $urandom, $urandom}, acc);
         else tick();
      end
      drain("rand_drain");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
